// File: rtl/l2c_xout_fifo.sv
// l2c_xout_fifo
//   Request buffer between the L2C cross-unit output arbiter and the cross unit.
//   Arbitrated requests are accepted through a req/ack handshake and stored in a
//   DEPTH-entry FIFO. They are presented in order to the cross unit. The payload
//   is carried unmodified.
//
//   Optional build macro: L2C_XOUT_FIFO_BYPASS_EN
//     When defined, an empty FIFO presents in_* combinationally on the out port.
//     If the cross unit acks in that same cycle, the entry is never written.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   in_req / in_ack     upstream handshake; payload in_cmd..in_data
//   out_req / out_ack   downstream handshake; payload out_cmd..out_data (head entry)
//   count               occupancy 0..DEPTH
//   overflow_err        sticky; upstream dropped or changed an un-acked request
module l2c_xout_fifo #(
  parameter int DEPTH          = 4,
  parameter int PTR_W          = 2,
  parameter int XU_L2C_CMD_W   = 3,
  parameter int CORE_ADDR_W    = 32,
  parameter int CORE_UID_W     = 8,
  parameter int CPU_TILE_ID_W  = 4,
  parameter int CORE_DATA_BE_W = 8,
  parameter int CORE_DATA_W    = 64,
  parameter logic [XU_L2C_CMD_W-1:0] XU_L2C_CMD_NO = '0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_req,
  input  logic [XU_L2C_CMD_W-1:0]   in_cmd,
  input  logic [CORE_ADDR_W-1:0]    in_addr,
  input  logic [CORE_UID_W-1:0]     in_uid,
  input  logic [CPU_TILE_ID_W-1:0]  in_src,
  input  logic [CORE_DATA_BE_W-1:0] in_data_be,
  input  logic [CORE_DATA_W-1:0]    in_data,
  output logic                      in_ack,
  output logic                      out_req,
  output logic [XU_L2C_CMD_W-1:0]   out_cmd,
  output logic [CORE_ADDR_W-1:0]    out_addr,
  output logic [CORE_UID_W-1:0]     out_uid,
  output logic [CPU_TILE_ID_W-1:0]  out_src,
  output logic [CORE_DATA_BE_W-1:0] out_data_be,
  output logic [CORE_DATA_W-1:0]    out_data,
  input  logic                      out_ack,
  output logic [PTR_W:0]            count,
  output logic                      overflow_err
);

  localparam int PL_W = XU_L2C_CMD_W + CORE_ADDR_W + CORE_UID_W + CPU_TILE_ID_W
                      + CORE_DATA_BE_W + CORE_DATA_W;

  // The empty-FIFO payload: only cmd carries a non-zero "no command" code.
  localparam logic [PL_W-1:0] PL_IDLE = {XU_L2C_CMD_NO, {(PL_W-XU_L2C_CMD_W){1'b0}}};

  logic [PTR_W:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]    rd_ptr_q, rd_ptr_d;
  logic [PL_W-1:0]   mem_q [DEPTH];
  logic [PL_W-1:0]   mem_d [DEPTH];
  logic              pend_q, pend_d;
  logic [PL_W-1:0]   hold_pl_q, hold_pl_d;
  logic              ovf_q, ovf_d;

  logic [PL_W-1:0]   in_pl;
  logic [PL_W-1:0]   out_pl;
  logic              empty;
  logic              full;
  logic              bypass;
  logic              push;
  logic              pop;

  assign in_pl = {in_cmd, in_addr, in_uid, in_src, in_data_be, in_data};

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]) &&
                 (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]);

`ifdef L2C_XOUT_FIFO_BYPASS_EN
  assign bypass = empty & in_req;
`else
  assign bypass = 1'b0;
`endif

  // in_ack depends only on state and in_req, never on out_ack.
  assign in_ack = in_req & ~full;
  // A bypassed entry consumed in the same cycle is never written.
  assign push   = in_ack & ~(bypass & out_ack);
  assign pop    = ~empty & out_ack;

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    mem_d     = mem_q;
    pend_d    = in_req & ~in_ack;
    hold_pl_d = in_pl;
    ovf_d     = ovf_q;
    if (push) begin
      mem_d[wr_ptr_q[PTR_W-1:0]] = in_pl;
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    // Upstream must hold an un-acked request stable until it is accepted.
    if (pend_q && (!in_req || (in_pl != hold_pl_q))) begin
      ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      pend_q    <= 1'b0;
      hold_pl_q <= '0;
      ovf_q     <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      pend_q    <= pend_d;
      hold_pl_q <= hold_pl_d;
      ovf_q     <= ovf_d;
    end
  end

  // Storage is not reset; the pointers alone define which entries are valid.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_comb begin
    out_pl = PL_IDLE;
    if (!empty) begin
      out_pl = mem_q[rd_ptr_q[PTR_W-1:0]];
    end else if (bypass) begin
      out_pl = in_pl;
    end
  end

  assign out_req = ~empty | bypass;
  assign {out_cmd, out_addr, out_uid, out_src, out_data_be, out_data} = out_pl;
  assign count        = wr_ptr_q - rd_ptr_q;
  assign overflow_err = ovf_q;

endmodule

// File: tb/tb_l2c_xout_fifo.sv
module tb_l2c_xout_fifo;

`ifdef L2C_XOUT_FIFO_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        in_req;
  logic [2:0]  in_cmd;
  logic [31:0] in_addr;
  logic [7:0]  in_uid;
  logic [3:0]  in_src;
  logic [7:0]  in_data_be;
  logic [63:0] in_data;
  logic        in_ack;
  logic        out_req;
  logic [2:0]  out_cmd;
  logic [31:0] out_addr;
  logic [7:0]  out_uid;
  logic [3:0]  out_src;
  logic [7:0]  out_data_be;
  logic [63:0] out_data;
  logic        out_ack;
  logic [2:0]  count;
  logic        overflow_err;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  l2c_xout_fifo dut (
    .clk(clk), .rst(rst),
    .in_req(in_req), .in_cmd(in_cmd), .in_addr(in_addr), .in_uid(in_uid),
    .in_src(in_src), .in_data_be(in_data_be), .in_data(in_data), .in_ack(in_ack),
    .out_req(out_req), .out_cmd(out_cmd), .out_addr(out_addr), .out_uid(out_uid),
    .out_src(out_src), .out_data_be(out_data_be), .out_data(out_data),
    .out_ack(out_ack), .count(count), .overflow_err(overflow_err)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance one edge; inputs are changed and outputs sampled at negedge+1.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic drive(input logic req, input logic [31:0] addr, input logic [7:0] uid);
    in_req     = req;
    in_cmd     = 3'd5;
    in_addr    = addr;
    in_uid     = uid;
    in_src     = 4'hA;
    in_data_be = 8'h0F;
    in_data    = {addr, ~addr};
    #1;
  endtask

  initial begin
    rst = 1'b1; out_ack = 1'b0;
    drive(1'b0, 32'h0, 8'h0);
    step(); step();
    rst = 1'b0;
    step();

    // 1: reset / idle
    chk("rst_out_req", out_req, 0);
    chk("rst_count", count, 0);
    chk("rst_cmd", out_cmd, 0);
    chk("rst_addr", out_addr, 0);
    chk("rst_ovf", overflow_err, 0);
    drive(1'b1, 32'h0, 8'h0);
    chk("rst_in_ack", in_ack, 1);
    chk("idle_out_req_with_in_req", out_req, BYP);
    drive(1'b0, 32'h0, 8'h0);
    step();

    // 2: fill with four entries, no pops
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'h100 + 32'(4*i), 8'(i));
      chk("fill_in_ack", in_ack, 1);
      step();
    end
    chk("full_count", count, 4);
    drive(1'b1, 32'h110, 8'd4);
    chk("full_in_ack", in_ack, 0);

    // 3: full, push and pop together -> only pop
    out_ack = 1'b1; #1;
    chk("full_pop_in_ack", in_ack, 0);
    chk("full_head_addr", out_addr, 32'h100);
    chk("full_head_data", out_data, {32'h100, ~32'h100});
    step();
    chk("after_pop_count", count, 3);
    out_ack = 1'b0; #1;
    chk("refill_in_ack", in_ack, 1);
    step();
    chk("refill_count", count, 4);
    drive(1'b0, 32'h0, 8'h0);

    // 2 (cont.): drain in order
    out_ack = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("drain_out_req", out_req, 1);
      chk("drain_addr", out_addr, 32'h104 + 32'(4*i));
      step();
    end
    chk("drain_count", count, 0);
    chk("drain_out_req_empty", out_req, 0);
    chk("drain_ovf", overflow_err, 0);

    // 4: streaming 10 entries across pointer wrap
    for (int k = 0; k < 10; k++) begin
      drive(1'b1, 32'h400, 8'(k));
      chk("stream_in_ack", in_ack, 1);
      if (k > 0 || BYP) begin
        chk("stream_uid", out_uid, BYP ? 64'(k) : 64'(k - 1));
        chk("stream_count", count, BYP ? 0 : 1);
      end
      step();
    end
    drive(1'b0, 32'h0, 8'h0);
    if (!BYP) begin
      chk("stream_last_uid", out_uid, 9);
      step();
    end
    chk("stream_end_count", count, 0);
    out_ack = 1'b0;

    // 6: empty, in_req with out_ack in the same cycle
    drive(1'b1, 32'h200, 8'h20);
    out_ack = 1'b1; #1;
    chk("byp_in_ack", in_ack, 1);
    chk("byp_out_req", out_req, BYP);
    chk("byp_out_addr", out_addr, BYP ? 32'h200 : 32'h0);
    step();
    drive(1'b0, 32'h0, 8'h0);
    chk("byp_count", count, BYP ? 0 : 1);
    if (!BYP) begin
      chk("byp_late_addr", out_addr, 32'h200);
      step();
    end
    out_ack = 1'b0;
    chk("byp_end_count", count, 0);

    // 5: overflow while full
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'h500 + 32'(i), 8'(i));
      step();
    end
    drive(1'b1, 32'h300, 8'h30);
    step();
    chk("ovf_held_stable", overflow_err, 0);
    drive(1'b1, 32'h304, 8'h30);
    step();
    chk("ovf_set", overflow_err, 1);
    drive(1'b0, 32'h0, 8'h0);
    step();
    chk("ovf_sticky", overflow_err, 1);
    chk("ovf_count", count, 4);
    rst = 1'b1;
    step();
    rst = 1'b0; #1;
    chk("post_rst_count", count, 0);
    chk("post_rst_out_req", out_req, 0);
    chk("post_rst_ovf", overflow_err, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
